// File: rtl/sr_flag_scheduler_if.sv
// Request/flag bus between control agents and the flag scheduler.
//   master : agent side   - drives req/op/idx/clr_all, observes ack/gnt_id/q
//   slave  : scheduler    - observes req/op/idx/clr_all, drives ack/gnt_id/q
//   req     [NREQ]        request per requester, held until acknowledged
//   op      [2*NREQ]      per-requester opcode: 00 nop, 01 clear, 10 set, 11 toggle
//   idx     [IDXW*NREQ]   per-requester flag index
//   clr_all               clear the whole bank, beats every request
//   ack     [NREQ]        one-cycle one-hot acknowledge
//   gnt_id  [GW]          id of the last serviced requester
//   q       [NFLAGS]      flag bank
interface sr_flag_scheduler_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8
);
    localparam int unsigned IDXW = $clog2(NFLAGS);
    localparam int unsigned GW   = $clog2(NREQ);

    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [IDXW*NREQ-1:0] idx;
    logic                 clr_all;
    logic [NREQ-1:0]      ack;
    logic [GW-1:0]        gnt_id;
    logic [NFLAGS-1:0]    q;

    modport master (
        output req, op, idx, clr_all,
        input  ack, gnt_id, q
    );

    modport slave (
        input  req, op, idx, clr_all,
        output ack, gnt_id, q
    );
endinterface

// File: rtl/sr_flag_scheduler.sv
// Shared SR-style flag bank with a round-robin request scheduler.
// One request per cycle is applied to the bank; the serviced requester gets a
// one-cycle ack coincident with the flag update.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sr_flag_scheduler_if.slave (req/op/idx/clr_all in, ack/gnt_id/q out)
module sr_flag_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8
) (
    input logic              clk,
    input logic              rst,
    sr_flag_scheduler_if.slave bus
);
    localparam int unsigned IDXW = $clog2(NFLAGS);
    localparam int unsigned GW   = $clog2(NREQ);

    typedef enum logic [1:0] {
        OpNop = 2'b00,
        OpClr = 2'b01,
        OpSet = 2'b10,
        OpTgl = 2'b11
    } op_e;

    logic [NFLAGS-1:0] q_q, q_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [GW-1:0]     gnt_q;
    logic [GW-1:0]     ptr_q, ptr_d;

    logic [NREQ-1:0]   elig;
    logic              found;
    logic [GW-1:0]     win;
    logic [1:0]        win_op;
    logic [IDXW-1:0]   win_idx;
    logic              idx_ok;

    // A requester acked last cycle is masked so a held req cannot win twice in a row.
    assign elig = bus.req & ~ack_q;

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin : arbitrate
        int unsigned pos;
        logic [GW-1:0] cand;
        found = 1'b0;
        win   = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = GW'(pos);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Select the winner's opcode and index.
    always_comb begin : select
        win_op  = 2'b00;
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                win_op  = bus.op[2*i +: 2];
                win_idx = bus.idx[IDXW*i +: IDXW];
            end
        end
    end

    // Indices past the bank are acked but leave q untouched.
    assign idx_ok = 32'(win_idx) < NFLAGS;

    always_comb begin : update
        q_d   = q_q;
        ack_d = '0;
        ptr_d = ptr_q;
        if (found) begin
            ack_d[win] = 1'b1;
            ptr_d      = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
            if (idx_ok) begin
                unique case (op_e'(win_op))
                    OpNop: ;
                    OpClr: q_d[win_idx] = 1'b0;
                    OpSet: q_d[win_idx] = 1'b1;
                    OpTgl: q_d[win_idx] = ~q_q[win_idx];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            ack_q <= '0;
            gnt_q <= '0;
            ptr_q <= '0;
        end else if (bus.clr_all) begin
            // Pending requests stay pending; pointer and last grant are kept.
            q_q   <= '0;
            ack_q <= '0;
        end else begin
            q_q   <= q_d;
            ack_q <= ack_d;
            ptr_q <= ptr_d;
            if (found) begin
                gnt_q <= win;
            end
        end
    end

    assign bus.q      = q_q;
    assign bus.ack    = ack_q;
    assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Self-checking bench for sr_flag_scheduler: directed scenarios plus a
// randomized phase, all compared against a behavioural model of the bank.
module tb_sr_flag_scheduler;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned NFLAGS = 8;
    localparam int unsigned IDXW   = $clog2(NFLAGS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_flag_scheduler_if #(.NREQ(NREQ), .NFLAGS(NFLAGS)) bus ();

    sr_flag_scheduler #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: what the outputs must show after the next edge.
    bit [NFLAGS-1:0] m_q;
    bit [NREQ-1:0]   m_ack;
    int              m_gnt;
    int              m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_update();
        int w;
        int o;
        int f;
        if (rst) begin
            m_q = '0; m_ack = '0; m_gnt = 0; m_ptr = 0;
        end else if (bus.clr_all) begin
            m_q = '0; m_ack = '0;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int r;
                r = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req[r] && !m_ack[r]) w = r;
            end
            m_ack = '0;
            if (w >= 0) begin
                o = int'(bus.op[2*w +: 2]);
                f = int'(bus.idx[IDXW*w +: IDXW]);
                if (f < NFLAGS) begin
                    case (o)
                        1: m_q[f] = 1'b0;
                        2: m_q[f] = 1'b1;
                        3: m_q[f] = ~m_q[f];
                        default: ;
                    endcase
                end
                m_ack[w] = 1'b1;
                m_gnt    = w;
                m_ptr    = (w + 1) % NREQ;
            end
        end
    endfunction

    // One clock: advance model, take the edge, compare all outputs.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("q", 64'(bus.q), 64'(m_q));
        check("ack", 64'(bus.ack), 64'(m_ack));
        check("gnt_id", 64'(bus.gnt_id), 64'(m_gnt));
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input int f);
        bus.op[2*i +: 2]       = o;
        bus.idx[IDXW*i +: IDXW] = IDXW'(f);
        bus.req[i]             = 1'b1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int gcount [NREQ];

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.op      = '0;
        bus.idx     = '0;
        bus.clr_all = 1'b0;

        // Reset held two cycles with all requesters asking.
        bus.req = 4'b1111;
        step();
        step();
        check("rst_q", 64'(bus.q), 64'h00);
        check("rst_ack", 64'(bus.ack), 64'h0);
        check("rst_gnt", 64'(bus.gnt_id), 64'h0);
        rst = 1'b0;
        step();
        check("first_grant", 64'(bus.ack), 64'b0001);
        bus.req = '0;
        step();

        // Single set then clear on flag 5 by requester 2.
        set_req(2, 2'b10, 5);
        step();
        check("set_q", 64'(bus.q), 64'h20);
        check("set_ack", 64'(bus.ack), 64'b0100);
        set_req(2, 2'b01, 5);
        step();
        check("held_masked", 64'(bus.ack), 64'h0);
        step();
        check("clr_q", 64'(bus.q), 64'h00);
        bus.req = '0;
        step();

        // Round-robin among requesters 0, 1, 3.
        do_reset();
        set_req(0, 2'b10, 0);
        set_req(1, 2'b10, 1);
        set_req(3, 2'b10, 3);
        step();
        check("rr_ack0", 64'(bus.ack), 64'b0001);
        bus.req[0] = 1'b0;
        step();
        check("rr_ack1", 64'(bus.ack), 64'b0010);
        bus.req[1] = 1'b0;
        step();
        check("rr_ack3", 64'(bus.ack), 64'b1000);
        check("rr_q", 64'(bus.q), 64'h0B);
        check("rr_gnt", 64'(bus.gnt_id), 64'd3);
        bus.req = '0;
        step();

        // Held toggle on flag 7: acks on alternate cycles.
        do_reset();
        set_req(1, 2'b11, 7);
        step();
        check("tgl_q1", 64'(bus.q), 64'h80);
        check("tgl_ack1", 64'(bus.ack), 64'b0010);
        step();
        check("tgl_ack2", 64'(bus.ack), 64'b0000);
        step();
        check("tgl_q3", 64'(bus.q), 64'h00);
        check("tgl_ack3", 64'(bus.ack), 64'b0010);
        step();
        bus.req = '0;
        step();

        // Fill the bank, then collide clr_all with a request.
        do_reset();
        for (int f = 0; f < NFLAGS; f++) begin
            set_req(0, 2'b10, f);
            step();
            step();
        end
        bus.req = '0;
        step();
        check("fill_q", 64'(bus.q), 64'hFF);
        set_req(0, 2'b10, 2);
        bus.clr_all = 1'b1;
        step();
        check("clrall_q", 64'(bus.q), 64'h00);
        check("clrall_ack", 64'(bus.ack), 64'h0);
        bus.clr_all = 1'b0;
        step();
        check("after_clr_q", 64'(bus.q), 64'h04);
        check("after_clr_ack", 64'(bus.ack), 64'b0001);
        bus.req = '0;
        step();

        // Reset after the second grant restarts service at requester 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b10, i);
        step();
        step();
        check("mid_ack2", 64'(bus.ack), 64'b0010);
        rst = 1'b1;
        step();
        check("mid_rst_ack", 64'(bus.ack), 64'h0);
        check("mid_rst_q", 64'(bus.q), 64'h00);
        rst = 1'b0;
        step();
        check("mid_restart", 64'(bus.ack), 64'b0001);
        bus.req = '0;
        step();

        // Fairness: all requesters held for 2*NREQ grants.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 2'b00, 0);
            gcount[i] = 0;
        end
        for (int c = 0; c < 2 * NREQ; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) gcount[i]++;
        end
        for (int i = 0; i < NREQ; i++) check("fair_count", 64'(gcount[i]), 64'd2);
        bus.req = '0;
        step();

        // Randomized traffic with occasional clr_all and reset.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            bus.clr_all = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (rst) begin
                    bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if (bus.ack[i]) begin
                        if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
                        else set_req(i, 2'($urandom), int'($urandom_range(0, NFLAGS - 1)));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 2'($urandom), int'($urandom_range(0, NFLAGS - 1)));
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
